// File: rtl/player_proj_collider.sv
// Player projectile vs. enemy formation collision scanner.
// Snapshots positions on a frame pulse, then tests one (projectile, enemy) pair per clock.
module player_proj_collider #(
  parameter int ROWS      = 3,
  parameter int COLS      = 8,
  parameter int IDX_W     = 5,
  parameter int ENEMY_W   = 32,
  parameter int ENEMY_H   = 24,
  parameter int SPACING_X = 48,
  parameter int SPACING_Y = 32,
  parameter int PROJ_W    = 4,
  parameter int PROJ_H    = 8,
  parameter int INACT_Y   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pulse_frame,
  input  logic [9:0]           proj1X,
  input  logic [9:0]           proj2X,
  input  logic [9:0]           proj3X,
  input  logic [8:0]           proj1Y,
  input  logic [8:0]           proj2Y,
  input  logic [8:0]           proj3Y,
  input  logic [9:0]           formX,
  input  logic [8:0]           formY,
  input  logic [ROWS*COLS-1:0] aliveMask,
  output logic                 projHit,
  output logic [1:0]           collidedProj,
  output logic                 enemyHit,
  output logic [IDX_W-1:0]     enemyIdx,
  output logic                 busy,
  output logic                 scanDone
);

  localparam int N     = ROWS * COLS;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [1:0]       p_q, p_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [10:0]      ex_q, ex_d;
  logic [9:0]       ey_q, ey_d;
  logic [N-1:0]     kill_q, kill_d;
  logic             projHit_d, enemyHit_d, busy_d, scanDone_d;
  logic [1:0]       collidedProj_d;
  logic [IDX_W-1:0] enemyIdx_d;

  logic [9:0] px1_q, px2_q, px3_q, fx_q;
  logic [8:0] py1_q, py2_q, py3_q, fy_q;

  logic [10:0] curX;
  logic [9:0]  curY;
  logic        active, hit, advance;

  always_comb begin
    case (p_q)
      2'd1:    begin curX = {1'b0, px1_q}; curY = {1'b0, py1_q}; end
      2'd2:    begin curX = {1'b0, px2_q}; curY = {1'b0, py2_q}; end
      default: begin curX = {1'b0, px3_q}; curY = {1'b0, py3_q}; end
    endcase
  end

  // Widened compares: the right/bottom edge sums must never wrap.
  assign active = (curY != 10'(INACT_Y));
  assign hit    = kill_q[idx_q] && active
                  && (curX < ex_q + 11'(ENEMY_W)) && (ex_q < curX + 11'(PROJ_W))
                  && (curY < ey_q + 10'(ENEMY_H)) && (ey_q < curY + 10'(PROJ_H));

  always_comb begin
    state_d        = state_q;
    p_d            = p_q;
    col_d          = col_q;
    idx_d          = idx_q;
    ex_d           = ex_q;
    ey_d           = ey_q;
    kill_d         = kill_q;
    projHit_d      = 1'b0;
    enemyHit_d     = 1'b0;
    scanDone_d     = 1'b0;
    busy_d         = busy;
    collidedProj_d = collidedProj;
    enemyIdx_d     = enemyIdx;
    advance        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pulse_frame) begin
          state_d = S_SCAN;
          busy_d  = 1'b1;
          p_d     = 2'd1;
          col_d   = '0;
          idx_d   = '0;
          ex_d    = {1'b0, formX};
          ey_d    = {1'b0, formY};
          kill_d  = aliveMask;
        end
      end
      S_SCAN: begin
        if (!active) begin
          advance = 1'b1;
        end else if (hit) begin
          projHit_d      = 1'b1;
          enemyHit_d     = 1'b1;
          collidedProj_d = p_q;
          enemyIdx_d     = idx_q;
          kill_d[idx_q]  = 1'b0;
          advance        = 1'b1;
        end else if (idx_q == LAST_IDX) begin
          advance = 1'b1;
        end else if (col_q == LAST_COL) begin
          col_d = '0;
          idx_d = idx_q + 1'b1;
          ex_d  = {1'b0, fx_q};
          ey_d  = ey_q + 10'(SPACING_Y);
        end else begin
          col_d = col_q + 1'b1;
          idx_d = idx_q + 1'b1;
          ex_d  = ex_q + 11'(SPACING_X);
        end
      end
      S_DONE: begin
        scanDone_d = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Leaving the current projectile: restart the enemy walk or finish the scan.
    if (advance) begin
      if (p_q == 2'd3) begin
        state_d = S_DONE;
        busy_d  = 1'b0;
      end else begin
        p_d   = p_q + 2'd1;
        col_d = '0;
        idx_d = '0;
        ex_d  = {1'b0, fx_q};
        ey_d  = {1'b0, fy_q};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      p_q          <= '0;
      col_q        <= '0;
      idx_q        <= '0;
      ex_q         <= '0;
      ey_q         <= '0;
      kill_q       <= '0;
      projHit      <= 1'b0;
      enemyHit     <= 1'b0;
      collidedProj <= '0;
      enemyIdx     <= '0;
      busy         <= 1'b0;
      scanDone     <= 1'b0;
    end else begin
      state_q      <= state_d;
      p_q          <= p_d;
      col_q        <= col_d;
      idx_q        <= idx_d;
      ex_q         <= ex_d;
      ey_q         <= ey_d;
      kill_q       <= kill_d;
      projHit      <= projHit_d;
      enemyHit     <= enemyHit_d;
      collidedProj <= collidedProj_d;
      enemyIdx     <= enemyIdx_d;
      busy         <= busy_d;
      scanDone     <= scanDone_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      px1_q <= '0; px2_q <= '0; px3_q <= '0; fx_q <= '0;
      py1_q <= '0; py2_q <= '0; py3_q <= '0; fy_q <= '0;
    end else if (state_q == S_IDLE && pulse_frame) begin
      px1_q <= proj1X; px2_q <= proj2X; px3_q <= proj3X; fx_q <= formX;
      py1_q <= proj1Y; py2_q <= proj2Y; py3_q <= proj3Y; fy_q <= formY;
    end
  end

endmodule

// File: tb/tb_player_proj_collider.sv
// Randomized and directed checks of player_proj_collider against a frame-level
// collision model that walks every projectile/enemy pair with plain arithmetic.
module tb_player_proj_collider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pulse_frame = 1'b0;
  logic [9:0]  proj1X = '0, proj2X = '0, proj3X = '0, formX = '0;
  logic [8:0]  proj1Y = '0, proj2Y = '0, proj3Y = '0, formY = '0;
  logic [23:0] aliveMask = '0;
  logic        projHit, enemyHit, busy, scanDone;
  logic [1:0]  collidedProj;
  logic [4:0]  enemyIdx;

  int testsRun = 0;
  int testsFailed = 0;

  int          mX[1:3];
  int          mY[1:3];
  int          mFX, mFY;
  logic [23:0] mAlive;
  bit          expHit[0:127];
  int          expCP[0:127];
  int          expIdx[0:127];
  int          doneEdge;
  int          curCP = 0;
  int          curIdx = 0;

  player_proj_collider dut (
    .clk(clk), .rst(rst), .pulse_frame(pulse_frame),
    .proj1X(proj1X), .proj2X(proj2X), .proj3X(proj3X),
    .proj1Y(proj1Y), .proj2Y(proj2Y), .proj3Y(proj3Y),
    .formX(formX), .formY(formY), .aliveMask(aliveMask),
    .projHit(projHit), .collidedProj(collidedProj), .enemyHit(enemyHit),
    .enemyIdx(enemyIdx), .busy(busy), .scanDone(scanDone)
  );

  always #5 clk = ~clk;

  // Expected hit schedule: scan cycle k is visible after the k-th edge following the pulse edge.
  task automatic modelFrame();
    int cyc = 0;
    logic [23:0] alive = mAlive;
    for (int i = 0; i < 128; i++) begin
      expHit[i] = 1'b0; expCP[i] = 0; expIdx[i] = 0;
    end
    for (int p = 1; p <= 3; p++) begin
      if (mY[p] == 0) begin
        cyc++;
        continue;
      end
      for (int idx = 0; idx < 24; idx++) begin
        int ex = mFX + (idx % 8) * 48;
        int ey = mFY + (idx / 8) * 32;
        cyc++;
        if (alive[idx] && mX[p] < ex + 32 && ex < mX[p] + 4 &&
            mY[p] < ey + 24 && ey < mY[p] + 8) begin
          expHit[cyc] = 1'b1; expCP[cyc] = p; expIdx[cyc] = idx;
          alive[idx] = 1'b0;
          break;
        end
      end
    end
    doneEdge = cyc + 1;
  endtask

  task automatic scrambleInputs();
    proj1X = 10'($urandom); proj2X = 10'($urandom); proj3X = 10'($urandom);
    proj1Y = 9'($urandom);  proj2Y = 9'($urandom);  proj3Y = 9'($urandom);
    formX = 10'($urandom); formY = 9'($urandom); aliveMask = 24'($urandom);
  endtask

  task automatic test_frame(input int x1, input int y1, input int x2, input int y2,
                            input int x3, input int y3, input int fx, input int fy,
                            input logic [23:0] alive);
    mX[1] = x1; mX[2] = x2; mX[3] = x3;
    mY[1] = y1; mY[2] = y2; mY[3] = y3;
    mFX = fx; mFY = fy; mAlive = alive;
    modelFrame();
    @(negedge clk);
    proj1X = 10'(x1); proj2X = 10'(x2); proj3X = 10'(x3);
    proj1Y = 9'(y1);  proj2Y = 9'(y2);  proj3Y = 9'(y3);
    formX = 10'(fx); formY = 9'(fy); aliveMask = alive;
    pulse_frame = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pulse_frame = 1'b0;
    testsRun++;
    if (busy !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL busy_start got=%0b exp=1", busy);
    end
    for (int e = 1; e <= doneEdge + 1; e++) begin
      scrambleInputs();
      pulse_frame = (e <= doneEdge) && ($urandom_range(0, 3) == 0);
      @(posedge clk);
      @(negedge clk);
      if (expHit[e]) begin
        curCP = expCP[e]; curIdx = expIdx[e];
      end
      testsRun++;
      if (projHit !== expHit[e]) begin
        testsFailed++; $display("[TB] FAIL projHit e=%0d got=%0b exp=%0b", e, projHit, expHit[e]);
      end
      testsRun++;
      if (enemyHit !== expHit[e]) begin
        testsFailed++; $display("[TB] FAIL enemyHit e=%0d got=%0b exp=%0b", e, enemyHit, expHit[e]);
      end
      testsRun++;
      if (collidedProj !== 2'(curCP)) begin
        testsFailed++; $display("[TB] FAIL collidedProj e=%0d got=%0d exp=%0d", e, collidedProj, curCP);
      end
      testsRun++;
      if (enemyIdx !== 5'(curIdx)) begin
        testsFailed++; $display("[TB] FAIL enemyIdx e=%0d got=%0d exp=%0d", e, enemyIdx, curIdx);
      end
      testsRun++;
      if (scanDone !== (e == doneEdge)) begin
        testsFailed++; $display("[TB] FAIL scanDone e=%0d got=%0b exp=%0b", e, scanDone, e == doneEdge);
      end
      testsRun++;
      if (busy !== (e < doneEdge - 1)) begin
        testsFailed++; $display("[TB] FAIL busy e=%0d got=%0b exp=%0b", e, busy, e < doneEdge - 1);
      end
    end
    pulse_frame = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    testsRun++;
    if ({projHit, enemyHit, busy, scanDone, collidedProj, enemyIdx} !== 11'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs got=%0h exp=0", {projHit, enemyHit, busy, scanDone, collidedProj, enemyIdx});
    end
    @(negedge clk);
    rst = 1'b0;
    curCP = 0; curIdx = 0;
  endtask

  task automatic test_directed();
    test_frame(110, 50, 0, 0, 0, 0, 100, 40, 24'hFFFFFF);
    test_frame(150, 80, 0, 0, 0, 0, 100, 40, 24'hFFFFFF);
    test_frame(110, 50, 110, 50, 0, 0, 100, 40, 24'hFFFFFF);
    test_frame(110, 50, 0, 0, 0, 0, 100, 40, 24'hFFFFFE);
    test_frame(30, 50, 0, 0, 0, 0, 1000, 40, 24'hFFFFFF);
    test_frame(1020, 200, 0, 0, 0, 0, 1000, 40, 24'hFFFFFF);
    test_frame(1000, 50, 0, 0, 0, 0, 1000, 40, 24'hFFFFFF);
    test_frame(0, 0, 0, 0, 0, 0, 100, 40, 24'hFFFFFF);
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      int fx = $urandom_range(0, 600);
      int fy = $urandom_range(0, 300);
      int xs[1:3];
      int ys[1:3];
      for (int p = 1; p <= 3; p++) begin
        xs[p] = fx + $urandom_range(0, 400);
        ys[p] = ($urandom_range(0, 4) == 0) ? 0 : fy + $urandom_range(0, 100);
      end
      test_frame(xs[1], ys[1], xs[2], ys[2], xs[3], ys[3], fx, fy, 24'($urandom));
    end
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    proj1X = 10'd300; proj1Y = 9'd110; proj2Y = 9'd0; proj3Y = 9'd0;
    formX = 10'd100; formY = 9'd40; aliveMask = 24'hFFFFFF;
    pulse_frame = 1'b1;
    @(negedge clk);
    pulse_frame = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    testsRun++;
    if ({projHit, enemyHit, busy, scanDone, collidedProj, enemyIdx} !== 11'd0) begin
      testsFailed++;
      $display("[TB] FAIL abort_outputs got=%0h exp=0", {projHit, enemyHit, busy, scanDone, collidedProj, enemyIdx});
    end
    @(negedge clk);
    rst = 1'b0;
    curCP = 0; curIdx = 0;
    for (int e = 0; e < 80; e++) begin
      @(negedge clk);
      testsRun++;
      if ({projHit, scanDone, busy} !== 3'b000) begin
        testsFailed++; $display("[TB] FAIL abort_quiet e=%0d got=%0b exp=000", e, {projHit, scanDone, busy});
      end
    end
    test_frame(300, 110, 0, 0, 0, 0, 100, 40, 24'hFFFFFF);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
